// File: rtl/freq_report.sv
// Frequency measurement front-end: takes a host command, starts the measurer,
// waits for its completion (or a local watchdog) and streams a checksummed report frame.
module freq_report #(
    parameter int CNT_NBIT  = 8,
    parameter int TO_NBIT   = 8,
    parameter int DATA_NBIT = 32,
    parameter int WD_CYCLES = 1 << 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CNT_NBIT-1:0]  cmd_cnt,
    input  logic [TO_NBIT-1:0]   cmd_timeout,
    output logic                 m_start,
    output logic [CNT_NBIT-1:0]  m_cnt_tgt,
    output logic [TO_NBIT-1:0]   m_timeout,
    input  logic                 m_done,
    input  logic [DATA_NBIT-1:0] m_freq,
    input  logic [CNT_NBIT-1:0]  m_cnt,
    input  logic                 m_err,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy
);

    localparam int NBYTES  = 3 + CNT_NBIT / 8 + DATA_NBIT / 8;
    localparam int FRAME_W = NBYTES * 8;
    localparam int BODY_W  = FRAME_W - 8;
    localparam int WD_W    = $clog2(WD_CYCLES) + 1;
    localparam int IDX_W   = $clog2(NBYTES) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_SEND
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               prev_done;
    logic               done_rise;
    logic               wd_expire;
    logic               accept;
    logic               byte_xfer;
    logic               last_byte;
    logic [WD_W-1:0]    wd_cnt;
    logic [IDX_W-1:0]   byte_idx;
    logic [FRAME_W-1:0] frame_p0;

    function automatic logic [7:0] xor_bytes(input logic [BODY_W-1:0] body);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < NBYTES - 1; i++) begin
            acc = acc ^ body[i*8 +: 8];
        end
        return acc;
    endfunction

    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [7:0]           status,
        input logic [CNT_NBIT-1:0]  cnt,
        input logic [DATA_NBIT-1:0] freq
    );
        logic [BODY_W-1:0] body;
        body = {8'hA5, status, cnt, freq};
        return {body, xor_bytes(body)};
    endfunction

    // A stale high m_done from an earlier run must not complete a new measurement.
    assign done_rise = m_done & ~prev_done;
    assign wd_expire = (wd_cnt == WD_W'(WD_CYCLES - 1));
    assign last_byte = (byte_idx == IDX_W'(NBYTES - 1));
    assign accept    = cmd_valid & cmd_ready;
    assign byte_xfer = (state == S_SEND) & tx_ready;
    assign tx_data   = (state == S_SEND) ? frame_p0[FRAME_W-1 -: 8] : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        m_start   = 1'b0;
        tx_valid  = 1'b0;
        busy      = 1'b1;
        unique case (state)
            S_IDLE: begin
                busy      = 1'b0;
                cmd_ready = ~rst;
                if (cmd_valid && !rst) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                m_start   = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (done_rise || wd_expire) begin
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                tx_valid = 1'b1;
                if (tx_ready && last_byte) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_done <= m_done;
            wd_cnt    <= '0;
            byte_idx  <= '0;
            m_cnt_tgt <= '0;
            m_timeout <= '0;
        end else begin
            prev_done <= m_done;
            if (accept) begin
                m_cnt_tgt <= cmd_cnt;
                m_timeout <= cmd_timeout;
            end
            if (state == S_START) begin
                wd_cnt <= '0;
            end else if (state == S_WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (byte_xfer) begin
                byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
            end
        end
    end

    // Frame capture stage: built whole on completion, then shifted out MSB byte first.
    always_ff @(posedge clk) begin
        if (state == S_WAIT && done_rise) begin
            frame_p0 <= build_frame({6'b0, 1'b0, m_err}, m_cnt, m_freq);
        end else if (state == S_WAIT && wd_expire) begin
            frame_p0 <= build_frame(8'h02, '0, '0);
        end else if (byte_xfer) begin
            frame_p0 <= frame_p0 << 8;
        end
    end

endmodule
